// File: rtl/aes_ctrl_pkg.sv
// Shared types and constants for the AES serial sequencing controller.
// Holds the controller state enum, sticky error codes and default
// serial lengths used by aes_spi_ctrl and aes_ctrl_bit_counter.
package aes_ctrl_pkg;

  localparam int unsigned KEY_BITS_DEF   = 256;
  localparam int unsigned BLOCK_BITS_DEF = 128;
  localparam int unsigned IDX_W          = 8;   // bit_idx width
  localparam int unsigned LIM_W          = 9;   // wide enough to hold 256
  localparam int unsigned ERR_W          = 2;

  localparam logic [ERR_W-1:0] ERR_NONE       = 2'd0;
  localparam logic [ERR_W-1:0] ERR_SHORT_LOAD = 2'd1;
  localparam logic [ERR_W-1:0] ERR_TIMEOUT    = 2'd2;
  localparam logic [ERR_W-1:0] ERR_SHORT_READ = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_LOAD_END,
    ST_START,
    ST_WAIT,
    ST_READY,
    ST_SHIFT
  } state_t;

endpackage

// File: rtl/aes_ctrl_bit_counter.sv
// Bit index counter shared by the serial load and result shift phases.
// Ports: clk, rst (sync, active-high); clr zeroes the index, inc advances
// it; limit is the phase length in bits; cnt is the registered index;
// last_c flags that cnt sits on the final bit (limit-1). The index never
// wraps: it holds at limit-1 until the next clr.
module aes_ctrl_bit_counter
  import aes_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  input  logic [LIM_W-1:0] limit,
  output logic [IDX_W-1:0] cnt,
  output logic             last_c
);

  assign last_c = ({1'b0, cnt} == (limit - LIM_W'(1)));

  // Saturating index register
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && !last_c) begin
      cnt <= cnt + IDX_W'(1);
    end
  end

endmodule

// File: rtl/aes_spi_ctrl.sv
// Sequencing controller between the serial host interface and the AES core.
// Counts the KEY_BITS serial load bits, pulses core_start once, waits for
// core_done, then gates the BLOCK_BITS result shift-out.
// Ports: clk, rst (sync, active-high), cs (host window), core_done (core
// completion pulse); outputs load_en, shift_en, bit_idx, core_start,
// result_ready, busy, err (sticky: 0 none, 1 short load, 2 timeout,
// 3 short read). All outputs are registered.
// Build option AES_CTRL_TIMEOUT_EN: adds the TIMEOUT parameter and a WAIT
// cycle counter that aborts with err=2 when core_done never arrives.
module aes_spi_ctrl
  import aes_ctrl_pkg::*;
#(
  parameter int unsigned KEY_BITS   = KEY_BITS_DEF,
  parameter int unsigned BLOCK_BITS = BLOCK_BITS_DEF
`ifdef AES_CTRL_TIMEOUT_EN
  ,
  parameter int unsigned TIMEOUT    = 1024
`endif
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cs,
  input  logic             core_done,
  output logic             load_en,
  output logic             shift_en,
  output logic [IDX_W-1:0] bit_idx,
  output logic             core_start,
  output logic             result_ready,
  output logic             busy,
  output logic [ERR_W-1:0] err
);

  state_t           state;
  state_t           state_nxt;
  logic [ERR_W-1:0] err_nxt;
  logic             cnt_clr;
  logic             cnt_inc;
  logic             last_c;
  logic [LIM_W-1:0] limit;
  logic             tmo_hit_c;

  // One counter serves both phases; only the length differs
  assign limit = (state == ST_SHIFT) ? LIM_W'(BLOCK_BITS) : LIM_W'(KEY_BITS);

  aes_ctrl_bit_counter u_bit_counter (
    .clk    (clk),
    .rst    (rst),
    .clr    (cnt_clr),
    .inc    (cnt_inc),
    .limit  (limit),
    .cnt    (bit_idx),
    .last_c (last_c)
  );

`ifdef AES_CTRL_TIMEOUT_EN
  localparam int unsigned TMO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  logic [TMO_W-1:0] tmo_cnt;

  // Counts cycles spent in WAIT; restarts whenever WAIT is left
  always_ff @(posedge clk) begin
    if (rst || (state != ST_WAIT)) begin
      tmo_cnt <= '0;
    end else begin
      tmo_cnt <= tmo_cnt + TMO_W'(1);
    end
  end

  assign tmo_hit_c = (tmo_cnt == TMO_W'(TIMEOUT - 1));
`else
  assign tmo_hit_c = 1'b0;
`endif

  // State and registered Moore outputs, decoded from the next state
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_IDLE;
      err          <= ERR_NONE;
      load_en      <= 1'b0;
      shift_en     <= 1'b0;
      core_start   <= 1'b0;
      result_ready <= 1'b0;
      busy         <= 1'b0;
    end else begin
      state        <= state_nxt;
      err          <= err_nxt;
      load_en      <= (state_nxt == ST_LOAD);
      shift_en     <= (state_nxt == ST_SHIFT);
      core_start   <= (state_nxt == ST_START);
      result_ready <= (state_nxt == ST_READY);
      busy         <= (state_nxt != ST_IDLE);
    end
  end

  // Next-state, error and counter control
  always_comb begin
    state_nxt = state;
    err_nxt   = err;
    cnt_clr   = 1'b0;
    cnt_inc   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (cs) begin
          state_nxt = ST_LOAD;
          err_nxt   = ERR_NONE;
          cnt_clr   = 1'b0 | 1'b1;
        end
      end
      ST_LOAD: begin
        // Final bit already captured: cs low here is a complete load
        if (last_c) begin
          state_nxt = cs ? ST_LOAD_END : ST_START;
        end else if (cs) begin
          cnt_inc = 1'b1;
        end else begin
          state_nxt = ST_IDLE;
          err_nxt   = ERR_SHORT_LOAD;
        end
      end
      ST_LOAD_END: begin
        if (!cs) begin
          state_nxt = ST_START;
        end
      end
      ST_START: begin
        state_nxt = ST_WAIT;
      end
      ST_WAIT: begin
        // core_done takes priority over an expiring timeout
        if (core_done) begin
          state_nxt = ST_READY;
        end else if (tmo_hit_c) begin
          state_nxt = ST_IDLE;
          err_nxt   = ERR_TIMEOUT;
        end
      end
      ST_READY: begin
        if (cs) begin
          state_nxt = ST_SHIFT;
          cnt_clr   = 1'b1;
        end
      end
      ST_SHIFT: begin
        if (last_c) begin
          state_nxt = ST_IDLE;
        end else if (cs) begin
          cnt_inc = 1'b1;
        end else begin
          state_nxt = ST_IDLE;
          err_nxt   = ERR_SHORT_READ;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

endmodule

// File: doc/aes_spi_ctrl.md
# aes_spi_ctrl

Sequencing controller between the serial host interface and the AES core. It counts the 256 serial load bits, fires a single start pulse to the core, and waits for completion with an optional timeout. It then gates the 128-bit serial result shift-out and reports status and errors to the host. It replaces the implicit cs-toggle direction flag with an explicit state machine.

## Interface
- KEY_BITS, 256, serial load length in bits (key + message)
- BLOCK_BITS, 128, serial result length in bits
- TIMEOUT, 1024, maximum core cycles from start to done
- clk  in  1  single clock; all logic on rising edge
- rst  in  1  reset, synchronous, active-high
- cs  in  1  host chip-select; high = transfer window
- core_done  in  1  one-cycle completion pulse from the AES core
- load_en  out  1  capture-enable for the serial-to-parallel registers
- shift_en  out  1  enable for the parallel-to-serial result output
- bit_idx  out  8  current bit index for the load or shift datapath
- core_start  out  1  one-cycle start pulse to the core
- result_ready  out  1  result held, awaiting host read window
- busy  out  1  high in any state other than IDLE
- err  out  2  sticky error code: 0 none, 1 short load, 2 timeout, 3 short read

## Operation
- States: IDLE, LOAD, LOAD_END, START, WAIT, READY, SHIFT.
- IDLE → LOAD when cs=1. bit_idx cleared to 0.
- LOAD:
  - load_en=1 every cycle cs=1.
  - bit_idx increments after each captured bit.
  - When bit KEY_BITS-1 is captured → LOAD_END.
  - cs=0 before that point → err=1, → IDLE.
- LOAD_END: wait for cs=0 → START. Extra clocks with cs=1 are ignored; load_en=0.
- START: core_start=1 for exactly one cycle → WAIT.
- WAIT:
  - core_done → READY.
  - core_done arriving in the START cycle is ignored.
- READY:
  - result_ready=1.
  - cs=1 → SHIFT with bit_idx=0.
- SHIFT:
  - shift_en=1 while cs=1.
  - bit_idx increments each cycle.
  - After bit BLOCK_BITS-1 → IDLE.
  - cs=0 early → err=3, → IDLE.
- err is cleared only by rst or by a new IDLE→LOAD transition.
- bit_idx wraps never: it is held at its final value until the next state entry.
- Simultaneous events:
  - cs falling on the same cycle the last load bit is captured counts as a complete load (→ START).
  - core_done and a timeout expiring on the same cycle: done wins.

## Timing
- All outputs registered (Moore). Reset values:
  - state=IDLE, bit_idx=0, err=0.
  - load_en, shift_en, core_start, result_ready, busy = 0.
- cs sampled high at edge n: LOAD entered at n+1, with load_en=1 and bit_idx=0 from n+1.
- A full load occupies KEY_BITS consecutive cycles.
- Core sequencing:
  - core_start is asserted 1 cycle after cs is sampled low in LOAD_END.
  - core_done sampled at edge m: result_ready=1 from m+1.
- Shift: first shift_en cycle is the cycle after cs is sampled high in READY. The output datapath drives the bit on the falling edge.
- rst mid-operation aborts on the next edge; no core_start is emitted.

## Configuration
- AES_CTRL_TIMEOUT_EN defined:
  - WAIT has a cycle counter.
  - On reaching TIMEOUT cycles without core_done: err=2, → IDLE.
- Undefined: no counter is synthesized; WAIT holds indefinitely until core_done or rst. err code 2 is never produced.

## Structure
- Package aes_ctrl_pkg holds:
  - state enum,
  - error-code constants (ERR_NONE, ERR_SHORT_LOAD, ERR_TIMEOUT, ERR_SHORT_READ),
  - default KEY_BITS/BLOCK_BITS.
- Sub-module aes_ctrl_bit_counter holds the bit_idx counter.
  - Inputs: clr, inc, limit.
  - Output: last flag.
  - Shared by LOAD and SHIFT.

## Test plan
- Normal flow:
  - cs high 256 cycles then low → load_en high exactly 256 cycles, bit_idx 0..255, core_start single pulse.
  - core_done after 20 cycles → result_ready; cs high 128 cycles → shift_en 128 cycles; back to IDLE with err=0.
- Short load: cs drops after 100 bits → err=1, IDLE, no core_start.
- Timeout (AES_CTRL_TIMEOUT_EN, TIMEOUT=16): no core_done → err=2 exactly 16 cycles after WAIT entry. Without the macro, the block stays in WAIT for 100 cycles and then completes on a late core_done.
- Short read: cs drops after 50 shift bits → err=3, IDLE, result_ready=0.
- rst asserted in mid-LOAD (bit 130) and in WAIT → all outputs at reset values on the next cycle. A following full transaction succeeds and clears err.
- Edge cases:
  - cs falls on the cycle bit 255 is captured → START, not an error.
  - core_done coincident with the timeout edge → READY.
